// File: rtl/sdram_access_arbiter.sv
// rtl/sdram_access_arbiter.sv - round-robin arbiter sharing one SDRAM port between playback reads and recording writes
module sdram_access_arbiter #(
   parameter int ADDR_W         = 23,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              play_read,
   input  logic [ADDR_W-1:0] play_addr,
   output logic [DATA_W-1:0] play_readdata,
   output logic              play_sdram_finished,
   input  logic              rec_write,
   input  logic [ADDR_W-1:0] rec_addr,
   input  logic [DATA_W-1:0] rec_writedata,
   output logic              rec_sdram_finished,
   output logic              sdram_read,
   output logic              sdram_write,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic [DATA_W-1:0] sdram_writedata,
   input  logic [DATA_W-1:0] sdram_readdata,
   input  logic              sdram_finished,
   output logic              busy,
   output logic              timeout_flag
);

   typedef enum logic [1:0] {IDLE, PLAY_GNT, REC_GNT} state_t;

   localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic        last_rec;
   logic [15:0] wdog;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state           <= IDLE;
         last_rec        <= 1'b1;
         wdog            <= 16'd0;
         sdram_addr      <= '0;
         sdram_writedata <= '0;
         sdram_read      <= 1'b0;
         sdram_write     <= 1'b0;
         timeout_flag    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // Play wins when alone, or when both request and record went last.
               if (play_read && (!rec_write || last_rec)) begin
                  state      <= PLAY_GNT;
                  sdram_read <= 1'b1;
                  sdram_addr <= play_addr;
                  last_rec   <= 1'b0;
                  wdog       <= 16'd0;
               end else if (rec_write) begin
                  state           <= REC_GNT;
                  sdram_write     <= 1'b1;
                  sdram_addr      <= rec_addr;
                  sdram_writedata <= rec_writedata;
                  last_rec        <= 1'b1;
                  wdog            <= 16'd0;
               end
            end
            PLAY_GNT, REC_GNT: begin
               if (sdram_finished) begin
                  state       <= IDLE;
                  sdram_read  <= 1'b0;
                  sdram_write <= 1'b0;
               end else if (wdog == WDOG_LAST) begin
                  state        <= IDLE;
                  sdram_read   <= 1'b0;
                  sdram_write  <= 1'b0;
                  timeout_flag <= 1'b1;
               end else begin
                  wdog <= wdog + 16'd1;
               end
            end
            default: begin
               state       <= IDLE;
               sdram_read  <= 1'b0;
               sdram_write <= 1'b0;
            end
         endcase
      end
   end

   // A requester that withdrew mid-grant gets no completion pulse.
   assign play_sdram_finished = (state == PLAY_GNT) && sdram_finished && play_read;
   assign rec_sdram_finished  = (state == REC_GNT) && sdram_finished && rec_write;
   assign play_readdata       = sdram_readdata;
   assign busy                = (state != IDLE);

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// tb/tb_sdram_access_arbiter.sv - scoreboard bench for sdram_access_arbiter
module tb_sdram_access_arbiter;
   localparam int K_PGNT = 0, K_RGNT = 1, K_PFIN = 2, K_RFIN = 3, K_PLEN = 4, K_RLEN = 5, K_TMO = 6;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        play_read = 1'b0;
   logic [22:0] play_addr = '0;
   logic [31:0] play_readdata;
   logic        play_sdram_finished;
   logic        rec_write = 1'b0;
   logic [22:0] rec_addr = '0;
   logic [31:0] rec_writedata = '0;
   logic        rec_sdram_finished;
   logic        sdram_read, sdram_write;
   logic [22:0] sdram_addr;
   logic [31:0] sdram_writedata;
   logic [31:0] sdram_readdata = '0;
   logic        sdram_finished = 1'b0;
   logic        busy, timeout_flag;

   typedef struct {
      int          kind;
      logic [31:0] a;
      logic [31:0] d;
   } evt_t;

   evt_t sb[$];
   int   compared = 0;
   int   mismatched = 0;
   int   rd_len = 0;
   int   wr_len = 0;
   logic prev_tmo = 1'b0;

   sdram_access_arbiter #(.ADDR_W(23), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .play_read(play_read), .play_addr(play_addr), .play_readdata(play_readdata),
      .play_sdram_finished(play_sdram_finished),
      .rec_write(rec_write), .rec_addr(rec_addr), .rec_writedata(rec_writedata),
      .rec_sdram_finished(rec_sdram_finished),
      .sdram_read(sdram_read), .sdram_write(sdram_write), .sdram_addr(sdram_addr),
      .sdram_writedata(sdram_writedata), .sdram_readdata(sdram_readdata),
      .sdram_finished(sdram_finished), .busy(busy), .timeout_flag(timeout_flag)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1, "bench time limit");
   end

   task automatic push(input int k, input logic [31:0] a, input logic [31:0] d);
      evt_t e;
      e.kind = k; e.a = a; e.d = d;
      sb.push_back(e);
   endtask

   task automatic check_evt(input int k, input logic [31:0] a, input logic [31:0] d);
      evt_t e;
      compared++;
      if (sb.size() == 0) begin
         mismatched++;
         $display("FAIL event: got kind=%0d a=%h d=%h, required no event", k, a, d);
      end else begin
         e = sb.pop_front();
         if (e.kind != k || e.a != a || e.d != d) begin
            mismatched++;
            $display("FAIL event: got kind=%0d a=%h d=%h, required kind=%0d a=%h d=%h",
                     k, a, d, e.kind, e.a, e.d);
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Monitor: every command rise/fall, finished pulse and timeout rise is an event.
   always @(negedge i_clk) begin
      compared++;
      if ((sdram_read && sdram_write) || (play_sdram_finished && rec_sdram_finished)) begin
         mismatched++;
         $display("FAIL exclusive: read=%b write=%b pfin=%b rfin=%b, required at most one of each pair",
                  sdram_read, sdram_write, play_sdram_finished, rec_sdram_finished);
      end
      if (!sdram_read && rd_len > 0) begin check_evt(K_PLEN, 0, 32'(rd_len)); rd_len = 0; end
      if (!sdram_write && wr_len > 0) begin check_evt(K_RLEN, 0, 32'(wr_len)); wr_len = 0; end
      if (sdram_read && rd_len == 0) check_evt(K_PGNT, 32'(sdram_addr), 0);
      if (sdram_write && wr_len == 0) check_evt(K_RGNT, 32'(sdram_addr), sdram_writedata);
      if (sdram_read) rd_len++;
      if (sdram_write) wr_len++;
      if (play_sdram_finished) check_evt(K_PFIN, 0, play_readdata);
      if (rec_sdram_finished) check_evt(K_RFIN, 0, sdram_writedata);
      if (timeout_flag && !prev_tmo) check_evt(K_TMO, 0, 0);
      prev_tmo = timeout_flag;
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      tick();
      tick();
      i_rst = 1'b0;
   endtask

   task automatic wait_cmd(output int n);
      n = 0;
      while (!(sdram_read || sdram_write) && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) begin
         compared++;
         mismatched++;
         $display("FAIL wait_cmd: no command after %0d cycles, required a grant", n);
      end
   endtask

   task automatic finish_after(input int n, input logic [31:0] data);
      repeat (n) tick();
      sdram_finished = 1'b1;
      sdram_readdata = data;
      tick();
      sdram_finished = 1'b0;
   endtask

   initial begin
      int n;
      do_reset();
      check("rst_read", 32'(sdram_read), 0);
      check("rst_write", 32'(sdram_write), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_tmo", 32'(timeout_flag), 0);
      check("rst_addr", 32'(sdram_addr), 0);
      check("rst_wdata", sdram_writedata, 0);

      // Single play read, finished in the fourth command cycle
      push(K_PGNT, 32'h123, 0); push(K_PFIN, 0, 32'hDEADBEEF); push(K_PLEN, 0, 4);
      play_read = 1'b1; play_addr = 23'h000123;
      wait_cmd(n);
      check("play_latency", 32'(n), 1);
      finish_after(3, 32'hDEADBEEF);
      play_read = 1'b0;
      check("play_idle_after", 32'(busy), 0);

      // Simultaneous requests alternate P, R, P, R; writedata change is ignored mid-grant
      do_reset();
      push(K_PGNT, 32'h200, 0); push(K_PFIN, 0, 32'h1000); push(K_PLEN, 0, 2);
      push(K_RGNT, 32'h10, 32'hA5A50000); push(K_RFIN, 0, 32'hA5A50000); push(K_RLEN, 0, 2);
      push(K_PGNT, 32'h200, 0); push(K_PFIN, 0, 32'h1002); push(K_PLEN, 0, 2);
      push(K_RGNT, 32'h10, 32'h0); push(K_RFIN, 0, 32'h0); push(K_RLEN, 0, 2);
      play_read = 1'b1; play_addr = 23'h200;
      rec_write = 1'b1; rec_addr = 23'h10; rec_writedata = 32'hA5A50000;
      for (int i = 0; i < 4; i++) begin
         wait_cmd(n);
         if (i == 1) rec_writedata = 32'h0;
         finish_after(1, 32'h1000 + 32'(i));
      end
      play_read = 1'b0; rec_write = 1'b0;

      // Play withdraws mid-grant; pending record wins on the next IDLE edge
      do_reset();
      push(K_PGNT, 32'h300, 0); push(K_PLEN, 0, 5);
      push(K_RGNT, 32'h40, 32'h11112222); push(K_RFIN, 0, 32'h11112222); push(K_RLEN, 0, 1);
      play_read = 1'b1; play_addr = 23'h300;
      rec_write = 1'b1; rec_addr = 23'h40; rec_writedata = 32'h11112222;
      wait_cmd(n);
      tick();
      play_read = 1'b0;
      finish_after(3, 32'h00000BAD);
      wait_cmd(n);
      check("rec_after_withdraw", 32'(n), 1);
      finish_after(0, 32'h0);
      rec_write = 1'b0;

      // Watchdog abort after 8 command cycles
      push(K_RGNT, 32'h50, 32'h77); push(K_RLEN, 0, 8); push(K_TMO, 0, 0);
      rec_write = 1'b1; rec_addr = 23'h50; rec_writedata = 32'h77;
      wait_cmd(n);
      n = 0;
      while (sdram_write && n < 30) begin tick(); n++; end
      rec_write = 1'b0;
      repeat (4) tick();
      check("tmo_sticky", 32'(timeout_flag), 1);
      check("tmo_idle", 32'(busy), 0);

      // Reset during a play grant, then simultaneous requests grant play first
      push(K_PGNT, 32'h60, 0); push(K_PLEN, 0, 2);
      play_read = 1'b1; play_addr = 23'h60;
      wait_cmd(n);
      tick();
      i_rst = 1'b1;
      tick();
      check("rstgnt_read", 32'(sdram_read), 0);
      check("rstgnt_busy", 32'(busy), 0);
      check("rstgnt_tmo", 32'(timeout_flag), 0);
      push(K_PGNT, 32'h70, 0); push(K_PFIN, 0, 32'hCAFE0001); push(K_PLEN, 0, 2);
      push(K_RGNT, 32'h80, 32'h99); push(K_RFIN, 0, 32'h99); push(K_RLEN, 0, 2);
      i_rst = 1'b0;
      play_addr = 23'h70;
      rec_write = 1'b1; rec_addr = 23'h80; rec_writedata = 32'h99;
      wait_cmd(n);
      finish_after(1, 32'hCAFE0001);
      play_read = 1'b0;
      wait_cmd(n);
      finish_after(1, 32'h0);
      rec_write = 1'b0;

      // Stray finished pulse while idle produces nothing
      tick();
      sdram_finished = 1'b1;
      tick();
      sdram_finished = 1'b0;
      tick();
      check("stray_idle", 32'(busy), 0);

      tick();
      check("sb_drained", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/sdram_access_arbiter.md
Name: sdram_access_arbiter

Overview:
Shares the single SDRAM port between the playback reader (play_*) and the recording writer (rec_*). Uses round-robin arbitration and locks the grant for the full transaction until the SDRAM controller signals finished. Latches address and write data at grant, routes the finished pulse only to the granted requester, and aborts hung transactions with a watchdog. Sits between PlayCore/RecCore and the SDRAM controller wrapper.

Parameters:
ADDR_W, 23, SDRAM word address width
DATA_W, 32, data width (one stereo sample: 16-bit L + 16-bit R)
TIMEOUT_CYCLES, 1023, max cycles in a grant state without sdram_finished before abort; legal range 2..65535

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
play_read  in  1  level read request; held until play_sdram_finished
play_addr  in  ADDR_W  read address
play_readdata  out  DATA_W  read data; combinational copy of sdram_readdata
play_sdram_finished  out  1  one-cycle completion pulse to the play requester
rec_write  in  1  level write request; held until rec_sdram_finished
rec_addr  in  ADDR_W  write address
rec_writedata  in  DATA_W  write data
rec_sdram_finished  out  1  one-cycle completion pulse to the record requester
sdram_read  out  1  read command to the SDRAM controller (level, held)
sdram_write  out  1  write command to the SDRAM controller (level, held)
sdram_addr  out  ADDR_W  latched address
sdram_writedata  out  DATA_W  latched write data
sdram_readdata  in  DATA_W  read data; valid in the sdram_finished cycle
sdram_finished  in  1  transaction complete pulse
busy  out  1  high in PLAY_GNT or REC_GNT
timeout_flag  out  1  sticky; set on any watchdog abort, cleared only by i_rst

Behaviour:
- Reset (sync, i_rst high at posedge): state=IDLE, last_grant=REC, wdog=0, sdram_addr=0, sdram_writedata=0, timeout_flag=0. All command and finished outputs are 0 while in IDLE.
- States:
  - IDLE: arbitrate on the current cycle's requests.
    - Only play_read high -> PLAY_GNT.
    - Only rec_write high -> REC_GNT.
    - Both high -> grant the requester that is not last_grant.
    - Neither -> stay in IDLE.
    - On the grant edge: latch sdram_addr from the winner's addr; for REC also latch sdram_writedata. Set last_grant to the winner and clear wdog.
  - PLAY_GNT: sdram_read=1.
    - If sdram_finished: drive play_sdram_finished=sdram_finished combinationally in the same cycle, then go to IDLE.
  - REC_GNT: sdram_write=1; same completion rule as PLAY_GNT, using rec_sdram_finished.
- Latency: request seen in cycle N -> command asserted in cycle N+1. After finished there is exactly one IDLE cycle before the next grant, so the minimum request-to-request period is 2 cycles plus SDRAM latency.
- A grant is never preempted. A request arriving during a grant waits in IDLE arbitration.
- Request withdrawn mid-grant (e.g. PlayCore stopped):
  - The command is still held until sdram_finished, because the SDRAM cannot be aborted.
  - If the requester's request is low in the finished cycle, its finished pulse is suppressed.
- Addr/data changes on requester inputs during a grant are ignored; the latched values are used.
- Watchdog: wdog increments each grant cycle without sdram_finished.
  - When wdog == TIMEOUT_CYCLES-1 and sdram_finished is low: drop the command, go to IDLE, and set timeout_flag. No finished pulse is sent, and last_grant is still updated.
  - sdram_finished in that same cycle counts as a normal completion.
- sdram_finished in IDLE (stray pulse) is ignored; no requester finished pulse.
- play_readdata = sdram_readdata at all times. The requester qualifies it with its finished pulse.
- Never assert sdram_read and sdram_write in the same cycle. The two finished outputs are mutually exclusive.
- i_rst during a grant: return to IDLE next edge with commands low; the in-flight SDRAM transaction is abandoned.

Test Plan:
- Single play read: play_read=1, play_addr=0x000123, SDRAM finishes 3 cycles after sdram_read and returns 0xDEADBEEF -> sdram_read high one cycle after request with sdram_addr=0x000123; play_sdram_finished pulses 1 cycle with play_readdata=0xDEADBEEF; back in IDLE next cycle.
- Simultaneous requests after reset: play_read=rec_write=1 with rec_addr=0x10, rec_writedata=0xA5A5_0000 -> PLAY granted first; after its finished, REC granted; with both still requesting, grants alternate PLAY, REC, PLAY, REC.
- Write data latch: rec_writedata changes to 0x0 one cycle after grant -> sdram_writedata stays 0xA5A5_0000 until rec_sdram_finished.
- Withdrawal: play_read drops 1 cycle after grant, finished arrives 4 cycles later -> sdram_read held 5 cycles; play_sdram_finished stays 0; rec_write pending is granted on the following IDLE edge.
- Watchdog: with TIMEOUT_CYCLES=8, grant REC and never assert sdram_finished -> sdram_write high exactly 8 cycles, then IDLE; timeout_flag=1 and stays 1 until i_rst; rec_sdram_finished never pulses.
- Reset mid-grant: i_rst during PLAY_GNT -> next cycle sdram_read=0, busy=0, timeout_flag=0; a subsequent simultaneous request grants PLAY first.
